axi_lite_2_wb_master: RTL and testbench

//  AXI-Lite slave to Wishbone master bridge; the initiator-facing counterpart of the WB->AXI bridge feeding the FIR.

---
 rtl/axi_lite_2_wb_master.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_2_wb_master.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_2_wb_master.sv
// AXI-Lite slave to classic Wishbone master bridge. Captures the AW, W and AR channels
// independently, arbitrates one transaction at a time and replays it as a single Wishbone
// cycle, aborting with SLVERR when the slave does not acknowledge in time.
module axi_lite_2_wb_master #(
  parameter int unsigned pADDR_WIDTH  = 12,
  parameter int unsigned pDATA_WIDTH  = 32,
  parameter logic [31:0] WB_BASE_ADDR = 32'h3800_0000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  // Write address channel
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [pADDR_WIDTH-1:0]   awaddr,
  // Write data channel
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [pDATA_WIDTH-1:0]   wdata,
  input  logic [pDATA_WIDTH/8-1:0] wstrb,
  // Write response channel
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  // Read address channel
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [pADDR_WIDTH-1:0]   araddr,
  // Read data channel
  output logic                     rvalid,
  input  logic                     rready,
  output logic [pDATA_WIDTH-1:0]   rdata,
  output logic [1:0]               rresp,
  // Wishbone master
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [pDATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [31:0]              wbm_adr_o,
  output logic [pDATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [pDATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                     wbm_ack_i
);

  localparam int unsigned StrbWidth  = pDATA_WIDTH / 8;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StWrBus,
    StWrResp,
    StRdBus,
    StRdResp
  } state_e;

  state_e state_q, state_d;

  // Captured AXI requests; a held capture stays until its response handshake completes.
  logic                   aw_held_q, aw_held_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                   w_held_q, w_held_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
  logic                   ar_held_q, ar_held_d;
  logic [pADDR_WIDTH-1:0] araddr_q, araddr_d;

  // Set when the most recent grant went to the read side; breaks write/read ties.
  logic                   last_rd_q, last_rd_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   arready_q, arready_d;

  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [StrbWidth-1:0]   sel_q, sel_d;
  logic [31:0]            adr_q, adr_d;
  logic [pDATA_WIDTH-1:0] dat_o_q, dat_o_d;

  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

  logic aw_fire, w_fire, ar_fire, wr_ready;

  assign aw_fire  = awvalid & awready_q;
  assign w_fire   = wvalid & wready_q;
  assign ar_fire  = arvalid & arready_q;
  assign wr_ready = aw_held_q & w_held_q;

  // Next-state: channel capture, arbitration, Wishbone cycle and response generation.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ar_held_d = ar_held_q;
    araddr_d  = araddr_q;
    last_rd_d = last_rd_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_o_d   = dat_o_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    // Readies are only ever high in idle, so captures cannot disturb a live transaction.
    if (aw_fire) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (ar_fire) begin
      ar_held_d = 1'b1;
      araddr_d  = araddr;
    end

    unique case (state_q)
      StIdle: begin
        if (wr_ready && (!ar_held_q || last_rd_q)) begin
          state_d   = StWrBus;
          last_rd_d = 1'b0;
          cnt_d     = '0;
          cyc_d     = 1'b1;
          we_d      = 1'b1;
          sel_d     = wstrb_q;
          adr_d     = WB_BASE_ADDR + 32'(awaddr_q);
          dat_o_d   = wdata_q;
        end else if (ar_held_q) begin
          state_d   = StRdBus;
          last_rd_d = 1'b1;
          cnt_d     = '0;
          cyc_d     = 1'b1;
          we_d      = 1'b0;
          sel_d     = '1;
          adr_d     = WB_BASE_ADDR + 32'(araddr_q);
        end
      end
      StWrBus: begin
        // An ack arriving on the final allowed cycle still completes with OKAY.
        if (wbm_ack_i) begin
          cyc_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RespOkay;
          state_d  = StWrResp;
        end else if (cnt_q == TimeoutCnt) begin
          cyc_d    = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RespSlvErr;
          state_d  = StWrResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWrResp: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      StRdBus: begin
        if (wbm_ack_i) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = RespOkay;
          rdata_d  = wbm_dat_i;
          state_d  = StRdResp;
        end else if (cnt_q == TimeoutCnt) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = RespSlvErr;
          rdata_d  = '0;
          state_d  = StRdResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRdResp: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          ar_held_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered readies track what the combinational form would show next cycle.
    awready_d = (state_d == StIdle) && !aw_held_d;
    wready_d  = (state_d == StIdle) && !w_held_d;
    arready_d = (state_d == StIdle) && !ar_held_d;
  end

  // State and output registers; reset drops any in-flight cycle without a response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ar_held_q <= 1'b0;
      araddr_q  <= '0;
      last_rd_q <= 1'b1;
      cnt_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_o_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ar_held_q <= ar_held_d;
      araddr_q  <= araddr_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_o_q   <= dat_o_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign arready   = arready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_o_q;

endmodule

// File: tb/tb_axi_lite_2_wb_master.sv
// Bench for axi_lite_2_wb_master: directed and randomized AXI-Lite traffic against a
// memory-backed Wishbone slave, checked with a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_lite_2_wb_master;

  localparam int unsigned To   = 8;
  localparam logic [31:0] Base = 32'h3800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [11:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [11:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i;

  always #5 clk = ~clk;

  axi_lite_2_wb_master #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .WB_BASE_ADDR(Base),
    .TIMEOUT     (To)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .bvalid   (bvalid),
    .bready   (bready),
    .bresp    (bresp),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc_count = 0;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Wishbone slave: memory that acks after ack_delay cycles of stb (-1 never acks).
  int          ack_delay = 0;
  logic        slv_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slv_mem [int unsigned];
  bit          in_cyc = 1'b0;
  int          stb_cnt = 0;
  int          cyc_len = 0;
  int unsigned cyc_start = 0;
  int          n_req = 0;
  logic [31:0] req_adr = '0, req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        req_we = 1'b0, req_stb = 1'b0;
  logic        we_hist [0:255];
  assign wbm_ack_i = slv_ack | stray_ack;

  always @(negedge clk) begin : wb_slave
    int unsigned idx;
    logic [31:0] word;
    if (wbm_cyc_o && !slv_ack) begin
      if (!in_cyc) begin
        in_cyc    = 1'b1;
        cyc_len   = 0;
        stb_cnt   = 0;
        cyc_start = cyc_count;
        req_adr   = wbm_adr_o;
        req_dat   = wbm_dat_o;
        req_sel   = wbm_sel_o;
        req_we    = wbm_we_o;
        req_stb   = wbm_stb_o;
        we_hist[n_req % 256] = wbm_we_o;
        n_req++;
      end
      cyc_len++;
      if (ack_delay >= 0 && stb_cnt == ack_delay) begin
        slv_ack = 1'b1;
        idx  = (wbm_adr_o - Base) >> 2;
        word = slv_mem.exists(idx) ? slv_mem[idx] : 32'd0;
        if (wbm_we_o) slv_mem[idx] = merge(word, wbm_dat_o, wbm_sel_o);
        else wbm_dat_i = word;
      end else begin
        stb_cnt++;
      end
    end else begin
      slv_ack = 1'b0;
      if (!wbm_cyc_o) in_cyc = 1'b0;
      wbm_dat_i = $urandom;
    end
  end

  // Reference model: word memory plus the last-grant bit used to resolve ties.
  logic [31:0] ref_mem [int unsigned];
  bit          ref_last_rd = 1'b1;

  function automatic logic [31:0] ref_read(logic [11:0] a);
    int unsigned idx;
    idx = int'(a[11:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
  endfunction

  function automatic bit acks(int d);
    return d >= 0 && d <= int'(To);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present AW/W/AR; lead -1 puts W two cycles before AW, +1 puts AW first.
  task automatic send(input bit do_wr, input bit do_rd, input logic [11:0] wa,
                      input logic [31:0] wd, input logic [3:0] ws, input logic [11:0] ra,
                      input int lead, output int unsigned acc);
    bit aw_done, w_done, ar_done, af, wf, rf;
    int aw_start, w_start;
    aw_done  = !do_wr;
    w_done   = !do_wr;
    ar_done  = !do_rd;
    aw_start = (lead < 0) ? 2 : 0;
    w_start  = (lead > 0) ? 2 : 0;
    acc      = 0;
    for (int t = 0; t < 50 && !(aw_done && w_done && ar_done); t++) begin
      @(negedge clk);
      awvalid = !aw_done && t >= aw_start;
      wvalid  = !w_done && t >= w_start;
      arvalid = !ar_done;
      awaddr  = wa;
      wdata   = wd;
      wstrb   = ws;
      araddr  = ra;
      af = awvalid && awready;
      wf = wvalid && wready;
      rf = arvalid && arready;
      if (af || wf || rf) acc = cyc_count;
      @(posedge clk);
      if (af) aw_done = 1'b1;
      if (wf) w_done = 1'b1;
      if (rf) ar_done = 1'b1;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    check("accepted", 32'({aw_done, w_done, ar_done}), 32'd7);
  endtask

  // Wait for a response, hold ready low for 'hold' cycles, then handshake it.
  task automatic get_resp(input bit is_wr, input int hold, input bit poke,
                          output logic [1:0] resp, output logic [31:0] data,
                          output int unsigned vcyc);
    bit seen;
    seen = 1'b0;
    resp = '0;
    data = '0;
    vcyc = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if ((is_wr ? bvalid : rvalid) === 1'b1) begin
        seen = 1'b1;
        vcyc = cyc_count;
      end
    end
    check(is_wr ? "bvalid_seen" : "rvalid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    resp = is_wr ? bresp : rresp;
    data = is_wr ? 32'd0 : rdata;
    check("other_valid_low", 32'(is_wr ? rvalid : bvalid), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        awvalid = 1'b1;
        wvalid  = 1'b1;
        awaddr  = 12'hABC;
        wdata   = 32'hDEAD_BEEF;
        wstrb   = 4'hF;
      end
      @(negedge clk);
      check("hold_valid", 32'(is_wr ? bvalid : rvalid), 32'd1);
      check("hold_resp", 32'(is_wr ? bresp : rresp), 32'(resp));
      if (!is_wr) check("hold_rdata", rdata, data);
      check("hold_ready_low", 32'({awready, wready, arready}), 32'd0);
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (is_wr) bready = 1'b1;
    else rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    rready = 1'b0;
    check("valid_cleared", 32'(is_wr ? bvalid : rvalid), 32'd0);
    check("ready_after", 32'(is_wr ? (awready & wready) : arready), 32'd1);
  endtask

  task automatic chk_write(input logic [11:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input int delay, input logic [1:0] resp);
    check("b_resp", 32'(resp), acks(delay) ? 32'd0 : 32'd2);
    check("wr_adr", req_adr, Base + 32'(wa));
    check("wr_we", 32'(req_we), 32'd1);
    check("wr_stb", 32'(req_stb), 32'd1);
    check("wr_sel", 32'(req_sel), 32'(ws));
    check("wr_dat", req_dat, wd);
    if (acks(delay)) ref_mem[int'(wa[11:2])] = merge(ref_read(wa), wd, ws);
    ref_last_rd = 1'b0;
  endtask

  task automatic chk_read(input logic [11:0] ra, input int delay, input logic [1:0] resp,
                          input logic [31:0] data);
    check("r_resp", 32'(resp), acks(delay) ? 32'd0 : 32'd2);
    check("r_data", data, acks(delay) ? ref_read(ra) : 32'd0);
    check("rd_adr", req_adr, Base + 32'(ra));
    check("rd_we", 32'(req_we), 32'd0);
    check("rd_sel", 32'(req_sel), 32'hF);
    ref_last_rd = 1'b1;
  endtask

  task automatic chk_timing(input int unsigned acc, input int unsigned vc, input int delay);
    int unsigned bus;
    bus = acks(delay) ? 32'(delay) + 1 : To + 1;
    check("lat_cyc", cyc_start - acc, 32'd2);
    check("lat_resp", vc - cyc_start, bus);
    check("cyc_len", 32'(cyc_len), bus);
  endtask

  task automatic txn_write(input logic [11:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input int lead, input int delay, input int hold, input bit poke);
    int unsigned acc, vc;
    logic [1:0]  resp;
    logic [31:0] data;
    ack_delay = delay;
    send(1'b1, 1'b0, wa, wd, ws, 12'h0, lead, acc);
    get_resp(1'b1, hold, poke, resp, data, vc);
    chk_write(wa, wd, ws, delay, resp);
    chk_timing(acc, vc, delay);
  endtask

  task automatic txn_read(input logic [11:0] ra, input int delay, input int hold);
    int unsigned acc, vc;
    logic [1:0]  resp;
    logic [31:0] data;
    ack_delay = delay;
    send(1'b0, 1'b1, 12'h0, 32'h0, 4'h0, ra, 0, acc);
    get_resp(1'b0, hold, 1'b0, resp, data, vc);
    chk_read(ra, delay, resp, data);
    chk_timing(acc, vc, delay);
  endtask

  // Write and read requested in the same cycle; model predicts the grant order.
  task automatic txn_tie(input logic [11:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [11:0] ra, input int delay);
    int unsigned acc, vc;
    int          n0;
    bit          wr_first;
    logic [1:0]  resp;
    logic [31:0] data;
    n0        = n_req;
    wr_first  = ref_last_rd;
    ack_delay = delay;
    send(1'b1, 1'b1, wa, wd, ws, ra, 0, acc);
    if (wr_first) begin
      get_resp(1'b1, 0, 1'b0, resp, data, vc);
      chk_write(wa, wd, ws, delay, resp);
      get_resp(1'b0, 0, 1'b0, resp, data, vc);
      chk_read(ra, delay, resp, data);
    end else begin
      get_resp(1'b0, 0, 1'b0, resp, data, vc);
      chk_read(ra, delay, resp, data);
      get_resp(1'b1, 0, 1'b0, resp, data, vc);
      chk_write(wa, wd, ws, delay, resp);
    end
    check("tie_order", 32'(we_hist[n0 % 256]), 32'(wr_first));
  endtask

  initial begin
    int unsigned acc;
    bit          seen;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'({awready, wready, arready}), 32'd0);
    check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
    check("rst_wb_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
    check("rst_wb_adr", wbm_adr_o, 32'd0);
    check("rst_wb_dat", wbm_dat_o, 32'd0);
    check("rst_resp", 32'({bresp, rresp}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'({awready, wready, arready}), 32'd7);

    // Basic write and read-back, reordered W-before-AW, partial strobes
    txn_write(12'h010, 32'h1234_5678, 4'hF, 0, 1, 0, 1'b0);
    txn_read(12'h010, 1, 0);
    txn_write(12'h024, 32'hCAFE_F00D, 4'b0101, -1, 0, 0, 1'b0);
    txn_read(12'h024, 0, 0);
    txn_write(12'h02B, 32'hA5A5_5A5A, 4'b1000, 1, 2, 0, 1'b0);
    txn_read(12'h029, 3, 0);

    // Ties: alternation follows the last grant
    txn_tie(12'h030, 32'h1111_2222, 4'hF, 12'h030, 1);
    txn_write(12'h034, 32'h3333_4444, 4'hF, 0, 0, 0, 1'b0);
    txn_tie(12'h034, 32'h5555_6666, 4'hF, 12'h034, 2);

    // Zero strobes still issue a cycle; ack on the last allowed cycle is OKAY
    txn_write(12'h010, 32'hFFFF_FFFF, 4'h0, 0, 1, 0, 1'b0);
    txn_read(12'h010, 0, 0);
    txn_write(12'h040, 32'h0BAD_CAFE, 4'hF, 0, int'(To), 0, 1'b0);

    // Timeouts, then a normal transaction
    txn_write(12'h044, 32'h7777_8888, 4'hF, 0, -1, 0, 1'b0);
    txn_read(12'h040, -1, 0);
    txn_read(12'h040, 0, 0);

    // Response back-pressure with new AW/W offered meanwhile
    txn_write(12'h048, 32'h9999_AAAA, 4'hF, 0, 1, 5, 1'b1);
    txn_read(12'h048, 1, 3);

    // Ack outside a cycle is ignored
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_ack", 32'({wbm_cyc_o, bvalid, rvalid}), 32'd0);

    // Reset in the middle of a bus cycle
    ack_delay = -1;
    send(1'b1, 1'b0, 12'h050, 32'h1357_9BDF, 4'hF, 12'h0, 0, acc);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (wbm_cyc_o === 1'b1) seen = 1'b1;
    end
    check("rst_cyc_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cyc", 32'({wbm_cyc_o, wbm_stb_o, bvalid}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_resp", 32'({bvalid, rvalid, wbm_cyc_o}), 32'd0);
    end
    check("rst_idle_ready", 32'({awready, wready, arready}), 32'd7);
    ref_last_rd = 1'b1;
    txn_read(12'h050, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      int          kind, delay, lead, hold;
      logic [11:0] wa, ra;
      logic [31:0] wd;
      logic [3:0]  ws;
      kind  = int'($urandom_range(0, 2));
      delay = int'($urandom_range(0, 9));
      if (delay == 9) delay = -1;
      lead  = int'($urandom_range(0, 2)) - 1;
      hold  = int'($urandom_range(0, 2));
      wa    = 12'h100 + 12'($urandom_range(0, 7) * 4) + 12'($urandom_range(0, 3));
      ra    = 12'h100 + 12'($urandom_range(0, 7) * 4) + 12'($urandom_range(0, 3));
      wd    = $urandom;
      ws    = 4'($urandom_range(0, 15));
      case (kind)
        0:       txn_write(wa, wd, ws, lead, delay, hold, 1'b0);
        1:       txn_read(ra, delay, hold);
        default: txn_tie(wa, wd, ws, ra, delay);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
